dot_product_accumulator: RTL and testbench

//  Sequential stage directly downstream of the combinational signed multiplier.

---
 rtl/dot_product_accumulator.sv | 87 ++++++++
 tb/tb_dot_product_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// Accumulates K consecutive signed products into one dot-product element and
// hands it to the result writer over valid/ready, holding it until taken.
module dot_product_accumulator #(
    parameter  int DATA_WIDTH = 4,
    parameter  int PROD_WIDTH = DATA_WIDTH + 4,
    parameter  int K          = 3,
    parameter  int ACC_WIDTH  = 12,
    localparam int CNT_W      = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [CNT_W-1:0]      cnt,
    output logic                  ovf
);

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 accept;
    logic                 add_ovf;
    logic                 last;

    assign in_ready = (state == ACCUM) && !clr && !rst;
    assign accept   = in_valid && in_ready;
    assign prod_ext = ACC_WIDTH'($signed(in_prod));
    assign sum      = acc + prod_ext;
    assign last     = (cnt == CNT_LAST);

    // Signed overflow: like-signed addends producing a sum of the other sign.
    assign add_ovf = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clr) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (accept) begin
                        if (add_ovf)
                            ovf <= 1'b1;
                        if (last) begin
                            out_sum   <= sum;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= DONE;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Result held stable; clr is deliberately ignored here.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: a K=3/12-bit instance and a
// K=2/8-bit instance for the wrap/overflow case.
module tb_dot_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: K=3, ACC_WIDTH=12
    logic        a_clr = 0, a_in_valid = 0, a_out_ready = 0;
    logic [7:0]  a_in_prod = '0;
    logic        a_in_ready, a_out_valid, a_ovf;
    logic [11:0] a_out_sum;
    logic [1:0]  a_cnt;

    // Instance B: K=2, ACC_WIDTH=8
    logic        b_clr = 0, b_in_valid = 0, b_out_ready = 0;
    logic [7:0]  b_in_prod = '0;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [7:0]  b_out_sum;
    logic [1:0]  b_cnt;

    dot_product_accumulator #(.DATA_WIDTH(4), .PROD_WIDTH(8), .K(3), .ACC_WIDTH(12)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_prod(a_in_prod), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .cnt(a_cnt), .ovf(a_ovf));

    dot_product_accumulator #(.DATA_WIDTH(4), .PROD_WIDTH(8), .K(2), .ACC_WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_prod(b_in_prod), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .cnt(b_cnt), .ovf(b_ovf));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [7:0] p);
        a_in_valid = 1;
        a_in_prod  = p;
        step();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", a_in_ready, 0);
        step();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_sum", a_out_sum, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_ovf", a_ovf, 0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", a_in_ready, 1);

        // 5 + (-3) + 7 = 9, held under backpressure
        a_beat(8'h05);
        chk("t1_cnt1", a_cnt, 1);
        a_beat(8'hFD);
        chk("t1_cnt2", a_cnt, 2);
        chk("t1_no_valid_yet", a_out_valid, 0);
        a_beat(8'h07);
        chk("t1_valid", a_out_valid, 1);
        chk("t1_sum", a_out_sum, 12'h009);
        chk("t1_ovf", a_ovf, 0);
        chk("t1_cnt0", a_cnt, 0);
        a_in_prod = 8'h55;
        for (int i = 0; i < 5; i++) begin
            a_clr = (i == 2);  // clr in DONE must be ignored
            #1;
            chk("bp_in_ready", a_in_ready, 0);
            step();
            chk("bp_valid", a_out_valid, 1);
            chk("bp_sum", a_out_sum, 12'h009);
        end
        a_clr = 0;
        a_in_valid = 0;
        a_out_ready = 1;
        step();
        chk("bp_release_valid", a_out_valid, 0);
        chk("bp_release_in_ready", a_in_ready, 1);

        // -16 x3 = -48, then 64 x3 = 192, out_ready held high
        a_beat(8'hF0);
        a_beat(8'hF0);
        a_beat(8'hF0);
        chk("t2_sum_neg", a_out_sum, 12'hFD0);
        chk("t2_valid_neg", a_out_valid, 1);
        a_beat(8'h40);  // DONE cycle: beat refused
        chk("t2_bubble_valid", a_out_valid, 0);
        chk("t2_bubble_cnt", a_cnt, 0);
        a_beat(8'h40);
        a_beat(8'h40);
        a_beat(8'h40);
        chk("t2_sum_pos", a_out_sum, 12'h0C0);
        chk("t2_ovf", a_ovf, 0);
        a_in_valid = 0;
        step();
        a_out_ready = 0;

        // clr after two accepts, clr concurrent with a valid beat
        a_beat(8'h10);
        a_beat(8'h10);
        chk("t3_cnt2", a_cnt, 2);
        a_clr = 1;
        a_in_prod = 8'h01;
        #1;
        chk("t3_clr_in_ready", a_in_ready, 0);
        step();
        chk("t3_clr_cnt", a_cnt, 0);
        chk("t3_clr_valid", a_out_valid, 0);
        a_clr = 0;
        a_beat(8'h01);
        a_beat(8'h01);
        a_beat(8'h01);
        chk("t3_sum", a_out_sum, 12'h003);
        a_in_valid = 0;
        a_out_ready = 1;
        step();
        a_out_ready = 0;

        // Gaps in in_valid: cnt holds
        a_beat(8'h02);
        a_in_valid = 0;
        step();
        chk("gap_cnt_hold", a_cnt, 1);
        a_beat(8'h03);
        a_beat(8'h04);
        chk("gap_sum", a_out_sum, 12'h009);
        a_in_valid = 0;
        a_out_ready = 1;
        step();
        a_out_ready = 0;

        // rst mid-accumulation, then rst while DONE
        a_beat(8'h05);
        a_in_valid = 0;
        rst = 1;
        #1;
        chk("rst_mid_cnt", a_cnt, 0);
        chk("rst_mid_in_ready", a_in_ready, 0);
        step();
        rst = 0;
        a_beat(8'h01);
        a_beat(8'h02);
        a_beat(8'h03);
        chk("rst_mid_fresh_sum", a_out_sum, 12'h006);
        chk("rst_mid_fresh_valid", a_out_valid, 1);
        a_in_valid = 0;
        rst = 1;
        #1;
        chk("rst_done_valid", a_out_valid, 0);
        chk("rst_done_sum", a_out_sum, 0);
        step();
        rst = 0;
        a_beat(8'h01);
        a_beat(8'h01);
        a_beat(8'h01);
        chk("rst_done_fresh_sum", a_out_sum, 12'h003);
        a_in_valid = 0;

        // 8-bit accumulator: 127 + 127 wraps to 0xFE with ovf
        b_in_valid = 1;
        b_in_prod = 8'h7F;
        step();
        chk("b_cnt1", b_cnt, 1);
        step();
        chk("b_sum_wrap", b_out_sum, 8'hFE);
        chk("b_ovf_set", b_ovf, 1);
        chk("b_valid", b_out_valid, 1);
        b_in_valid = 0;
        b_out_ready = 1;
        step();
        b_out_ready = 0;
        chk("b_ovf_sticky_accum", b_ovf, 1);
        b_in_valid = 1;
        b_in_prod = 8'h01;
        step();
        step();
        chk("b_sum_next", b_out_sum, 8'h02);
        chk("b_ovf_sticky_next", b_ovf, 1);
        b_in_valid = 0;
        b_clr = 1;  // ignored in DONE
        step();
        chk("b_clr_done_ovf", b_ovf, 1);
        b_clr = 0;
        b_out_ready = 1;
        step();
        b_out_ready = 0;
        b_clr = 1;
        step();
        b_clr = 0;
        chk("b_ovf_cleared", b_ovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
